// File: rtl/signal_sequencer.sv
// -----------------------------------------------------------------------------
// signal_sequencer
//
// Plays a stored pattern of {I,S} steps into a Moore state machine under test.
// Each step is held on I/S for HOLD clocks. A pass of Len steps starts on a
// sampled Start. Busy is high while the pass plays. Done pulses for one clock
// when a pass completes.
//
// Optional feature macro: SEQ_LOOP_EN
//   When it is defined, a Loop input is added. Loop is sampled on the final
//   clock of the last step. If Loop=1, playback restarts at step 0 with no
//   gap clock. Done still pulses once for every pass.
//
// Parameters:
//   DEPTH  pattern memory depth in steps (>=2)
//   HOLD   clocks each step is held on I/S (>=1)
//   AW     step index width, derived from DEPTH (do not override)
//
// Ports:
//   Clock    in   rising-edge clock
//   Reset    in   asynchronous active-high reset
//   Wr_en    in   pattern write strobe, honoured only in IDLE
//   Wr_addr  in   pattern write address
//   Wr_data  in   pattern step, [1]=I, [0]=S
//   Len      in   steps to play (1..DEPTH, clamped to DEPTH), sampled with Start
//   Start    in   begin playback
//   Loop     in   repeat playback (SEQ_LOOP_EN builds only)
//   I, S     out  registered stimulus bits
//   Busy     out  high while playback is in progress
//   Done     out  one-clock pulse when a pass completes
//   Step     out  index of the step currently on I/S
// -----------------------------------------------------------------------------
module signal_sequencer #(
    parameter int DEPTH = 16,
    parameter int HOLD  = 1,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          Clock,
    input  logic          Reset,
    input  logic          Wr_en,
    input  logic [AW-1:0] Wr_addr,
    input  logic [1:0]    Wr_data,
    input  logic [AW:0]   Len,
    input  logic          Start,
`ifdef SEQ_LOOP_EN
    input  logic          Loop,
`endif
    output logic          I,
    output logic          S,
    output logic          Busy,
    output logic          Done,
    output logic [AW-1:0] Step
);

    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t        state_reg;
    logic [1:0]    is_reg;
    logic          busy_reg;
    logic          done_reg;
    logic [AW-1:0] step_reg;
    logic [HW-1:0] hcnt_reg;
    logic [AW:0]   len_reg;

    // The pattern memory must clear on reset, so it is built from registers
    // instead of block RAM.
    logic [1:0] mem_reg [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_mem
            always_ff @(posedge Clock or posedge Reset) begin
                if (Reset) begin
                    mem_reg[gi] <= 2'b00;
                end else if (state_reg == IDLE && Wr_en && Wr_addr == AW'(gi)) begin
                    mem_reg[gi] <= Wr_data;
                end
            end
        end
    endgenerate

    logic loop_sel;
`ifdef SEQ_LOOP_EN
    assign loop_sel = Loop;
`else
    assign loop_sel = 1'b0;
`endif

    // A write to address 0 in the same clock as Start is forwarded.
    // This makes the first step play the value being written.
    logic [1:0]    first_step;
    logic [AW-1:0] next_idx;
    logic [AW:0]   len_clamped;
    logic          hold_end;
    logic          last_step;

    assign first_step  = (Wr_en && Wr_addr == '0) ? Wr_data : mem_reg[0];
    assign next_idx    = step_reg + AW'(1);
    assign len_clamped = (Len > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : Len;
    assign hold_end    = (hcnt_reg == HW'(HOLD - 1));
    assign last_step   = ({1'b0, step_reg} == len_reg - (AW+1)'(1));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_reg <= IDLE;
            is_reg    <= 2'b00;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            step_reg  <= '0;
            hcnt_reg  <= '0;
            len_reg   <= '0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (Start && Len != '0) begin
                        len_reg   <= len_clamped;
                        is_reg    <= first_step;
                        step_reg  <= '0;
                        hcnt_reg  <= '0;
                        busy_reg  <= 1'b1;
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    if (!hold_end) begin
                        hcnt_reg <= hcnt_reg + HW'(1);
                    end else begin
                        hcnt_reg <= '0;
                        if (!last_step) begin
                            step_reg <= next_idx;
                            is_reg   <= mem_reg[next_idx];
                        end else if (loop_sel) begin
                            // Back-to-back pass: no gap clock, and Busy stays high.
                            done_reg <= 1'b1;
                            step_reg <= '0;
                            is_reg   <= mem_reg[0];
                        end else begin
                            done_reg  <= 1'b1;
                            busy_reg  <= 1'b0;
                            step_reg  <= '0;
                            is_reg    <= 2'b00;
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign I    = is_reg[1];
    assign S    = is_reg[0];
    assign Busy = busy_reg;
    assign Done = done_reg;
    assign Step = step_reg;

endmodule

// File: tb/tb_signal_sequencer.sv
// -----------------------------------------------------------------------------
// tb_signal_sequencer
//
// Directed, table-driven bench for signal_sequencer.
// u_dut uses DEPTH=16 and HOLD=2. u_dut1 uses HOLD=1.
// Outputs are sampled 1 time unit after each rising edge. Each compared
// value is packed as {I,S,Busy,Done,Step[3:0]}.
// -----------------------------------------------------------------------------
module tb_signal_sequencer;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;

    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [1:0] wr_data = '0;
    logic [4:0] len = '0;
    logic       start = 1'b0;
    logic       loop = 1'b0;
    logic       i_o, s_o, busy_o, done_o;
    logic [3:0] step_o;

    logic       wr_en1 = 1'b0;
    logic [3:0] wr_addr1 = '0;
    logic [1:0] wr_data1 = '0;
    logic [4:0] len1 = '0;
    logic       start1 = 1'b0;
    logic       loop1 = 1'b0;
    logic       i1, s1, busy1, done1;
    logic [3:0] step1;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    signal_sequencer #(.DEPTH(16), .HOLD(2)) u_dut (
        .Clock(Clock), .Reset(Reset), .Wr_en(wr_en), .Wr_addr(wr_addr),
        .Wr_data(wr_data), .Len(len), .Start(start),
`ifdef SEQ_LOOP_EN
        .Loop(loop),
`endif
        .I(i_o), .S(s_o), .Busy(busy_o), .Done(done_o), .Step(step_o)
    );

    signal_sequencer #(.DEPTH(16), .HOLD(1)) u_dut1 (
        .Clock(Clock), .Reset(Reset), .Wr_en(wr_en1), .Wr_addr(wr_addr1),
        .Wr_data(wr_data1), .Len(len1), .Start(start1),
`ifdef SEQ_LOOP_EN
        .Loop(loop1),
`endif
        .I(i1), .S(s1), .Busy(busy1), .Done(done1), .Step(step1)
    );

    typedef struct {
        logic       we;
        logic [3:0] addr;
        logic [1:0] data;
        logic       st;
        logic [4:0] ln;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [7:0] ex(int is_v, int b, int d, int st);
        logic [1:0] is2;
        logic [3:0] st4;
        is2 = 2'(is_v);
        st4 = 4'(st);
        return {is2, 1'(b), 1'(d), st4};
    endfunction

    function automatic vec_t v(int we, int a, int d, int st, int l, logic [7:0] e);
        vec_t r;
        r.we   = 1'(we);
        r.addr = 4'(a);
        r.data = 2'(d);
        r.st   = 1'(st);
        r.ln   = 5'(l);
        r.exp  = e;
        return r;
    endfunction

    function automatic logic [7:0] outs0();
        return {i_o, s_o, busy_o, done_o, step_o};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic idle_inputs();
        wr_en = 1'b0;
        start = 1'b0;
        len   = '0;
    endtask

    initial begin
        int busy_cnt, done_cnt, step_max, seq_bad, k;
        logic [7:0] e;

        // Stimulus table for u_dut. Each field is {I,S,Busy,Done,Step}
        // after the edge.
        vecs.push_back(v(1, 0, 2, 0, 0, ex(0, 0, 0, 0)));   // mem0=10
        vecs.push_back(v(1, 1, 3, 0, 0, ex(0, 0, 0, 0)));   // mem1=11
        vecs.push_back(v(1, 2, 1, 0, 0, ex(0, 0, 0, 0)));   // mem2=01
        vecs.push_back(v(1, 3, 0, 0, 0, ex(0, 0, 0, 0)));   // mem3=00
        vecs.push_back(v(0, 0, 0, 1, 4, ex(2, 1, 0, 0)));   // Start Len=4
        vecs.push_back(v(0, 0, 0, 0, 0, ex(2, 1, 0, 0)));
        vecs.push_back(v(0, 0, 0, 0, 0, ex(3, 1, 0, 1)));
        vecs.push_back(v(0, 0, 0, 0, 0, ex(3, 1, 0, 1)));
        vecs.push_back(v(0, 0, 0, 0, 0, ex(1, 1, 0, 2)));
        vecs.push_back(v(0, 0, 0, 0, 0, ex(1, 1, 0, 2)));
        vecs.push_back(v(0, 0, 0, 0, 0, ex(0, 1, 0, 3)));
        vecs.push_back(v(0, 0, 0, 0, 0, ex(0, 1, 0, 3)));
        vecs.push_back(v(0, 0, 0, 0, 0, ex(0, 0, 1, 0)));   // Done
        vecs.push_back(v(0, 0, 0, 0, 0, ex(0, 0, 0, 0)));
        vecs.push_back(v(0, 0, 0, 1, 2, ex(2, 1, 0, 0)));   // Start Len=2
        vecs.push_back(v(1, 1, 0, 1, 4, ex(2, 1, 0, 0)));   // write+start ignored in RUN
        vecs.push_back(v(0, 0, 0, 1, 4, ex(3, 1, 0, 1)));   // mem1 still 11
        vecs.push_back(v(0, 0, 0, 0, 0, ex(3, 1, 0, 1)));
        vecs.push_back(v(0, 0, 0, 0, 0, ex(0, 0, 1, 0)));   // Done
        vecs.push_back(v(0, 0, 0, 1, 1, ex(2, 1, 0, 0)));   // Start in Done clock
        vecs.push_back(v(0, 0, 0, 0, 0, ex(2, 1, 0, 0)));
        vecs.push_back(v(0, 0, 0, 0, 0, ex(0, 0, 1, 0)));
        vecs.push_back(v(0, 0, 0, 1, 0, ex(0, 0, 0, 0)));   // Len=0 ignored
        vecs.push_back(v(0, 0, 0, 0, 0, ex(0, 0, 0, 0)));
        vecs.push_back(v(1, 0, 1, 1, 1, ex(1, 1, 0, 0)));   // write mem0=01 with Start
        vecs.push_back(v(0, 0, 0, 0, 0, ex(1, 1, 0, 0)));
        vecs.push_back(v(0, 0, 0, 0, 0, ex(0, 0, 1, 0)));
        vecs.push_back(v(0, 0, 0, 0, 0, ex(0, 0, 0, 0)));

        repeat (2) @(posedge Clock);
        #1;
        check("reset_state", 32'(outs0()), 32'(ex(0, 0, 0, 0)));
        @(negedge Clock);
        Reset = 1'b0;

        for (int n = 0; n < vecs.size(); n++) begin
            @(negedge Clock);
            wr_en   = vecs[n].we;
            wr_addr = vecs[n].addr;
            wr_data = vecs[n].data;
            start   = vecs[n].st;
            len     = vecs[n].ln;
            @(posedge Clock);
            #1;
            check($sformatf("vec%0d", n), 32'(outs0()), 32'(vecs[n].exp));
            $display("vec %0d outs=%b exp=%b", n, outs0(), vecs[n].exp);
        end

        // Len=20 clamps to 16 steps. Memory is 01,11,01,00, then zeros.
        @(negedge Clock);
        start = 1'b1;
        len   = 5'd20;
        busy_cnt = 0; done_cnt = 0; step_max = 0; seq_bad = 0;
        for (int c = 0; c < 60 && done_cnt == 0; c++) begin
            @(posedge Clock);
            #1;
            if (busy_o) begin
                busy_cnt++;
                if (int'(step_o) > step_max) step_max = int'(step_o);
                if (int'(step_o) != (busy_cnt - 1) / 2) seq_bad++;
            end
            if (done_o) done_cnt++;
            @(negedge Clock);
            idle_inputs();
        end
        check("len20_busy_clks", 32'(busy_cnt), 32'd32);
        check("len20_max_step", 32'(step_max), 32'd15);
        check("len20_step_seq", 32'(seq_bad), 32'd0);
        check("len20_done", 32'(done_cnt), 32'd1);
        $display("len20 busy=%0d max_step=%0d done=%0d", busy_cnt, step_max, done_cnt);

        // Assert Reset mid-run. mem1=11 should be on I/S when the reset lands.
        @(negedge Clock);
        start = 1'b1;
        len   = 5'd4;
        @(posedge Clock);
        @(negedge Clock);
        idle_inputs();
        @(posedge Clock);
        @(posedge Clock);
        #1;
        check("prereset_run", 32'(outs0()), 32'(ex(3, 1, 0, 1)));
        #2;
        Reset = 1'b1;
        #1;
        check("midrun_reset", 32'(outs0()), 32'(ex(0, 0, 0, 0)));
        @(negedge Clock);
        Reset = 1'b0;
        done_cnt = 0;
        repeat (10) begin
            @(posedge Clock);
            #1;
            if (done_o || busy_o) done_cnt++;
        end
        check("no_done_after_reset", 32'(done_cnt), 32'd0);
        // Memory was cleared, so mem0 (01 before the reset) now plays 00.
        @(negedge Clock);
        start = 1'b1;
        len   = 5'd1;
        @(posedge Clock);
        #1;
        check("mem_cleared", 32'(outs0()), 32'(ex(0, 1, 0, 0)));
        $display("reset test outs=%b", outs0());
        @(negedge Clock);
        idle_inputs();
        repeat (3) @(posedge Clock);

        // HOLD=1, Len=1, mem0=11.
        @(negedge Clock);
        wr_en1 = 1'b1; wr_addr1 = 4'd0; wr_data1 = 2'b11;
        @(negedge Clock);
        wr_en1 = 1'b0; start1 = 1'b1; len1 = 5'd1;
        @(posedge Clock);
        #1;
        check("hold1_step", 32'({i1, s1, busy1, done1, step1}), 32'(ex(3, 1, 0, 0)));
        @(negedge Clock);
        start1 = 1'b0;
        @(posedge Clock);
        #1;
        check("hold1_done", 32'({i1, s1, busy1, done1, step1}), 32'(ex(0, 0, 1, 0)));
        @(posedge Clock);
        #1;
        check("hold1_idle", 32'({i1, s1, busy1, done1, step1}), 32'(ex(0, 0, 0, 0)));
        $display("hold1 test outs=%b", {i1, s1, busy1, done1, step1});

`ifdef SEQ_LOOP_EN
        // Loop: Len=2, mem0=10, mem1=01. Loop stays high through passes 1-2
        // and is low when pass 3 ends.
        @(negedge Clock);
        wr_en = 1'b1; wr_addr = 4'd0; wr_data = 2'b10;
        @(negedge Clock);
        wr_addr = 4'd1; wr_data = 2'b01;
        done_cnt = 0;
        for (k = 0; k < 14; k++) begin
            @(negedge Clock);
            wr_en = 1'b0;
            start = (k == 0);
            len   = 5'd2;
            loop  = (k <= 10);
            @(posedge Clock);
            #1;
            if (k >= 12)
                e = ex(0, 0, (k == 12) ? 1 : 0, 0);
            else
                e = ex(((k % 4) < 2) ? 2 : 1, 1, (k == 4 || k == 8) ? 1 : 0,
                       ((k % 4) < 2) ? 0 : 1);
            if (done_o) done_cnt++;
            check($sformatf("loop_k%0d", k), 32'(outs0()), 32'(e));
            $display("loop k=%0d outs=%b exp=%b", k, outs0(), e);
        end
        check("loop_done_pulses", 32'(done_cnt), 32'd3);
        loop = 1'b0;
        idle_inputs();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
